booth_multiplier_module: RTL

Sequential signed multiplier built around the add/subtract stage: radix-2 Booth recoding, one add/subtract-and-shift step per clock. It consumes two two's-complement operands, drives repeated add or subtract operations into a widened accumulator, and returns a full-width signed product with a done pulse. It sits directly downstream of operand registers and is the consumer of the adder/subtracter datapath in the arithmetic section.

---
 rtl/booth_multiplier_module.sv | 101 ++++++++++
 1 files changed

// File: rtl/booth_multiplier_module.sv
// Sequential radix-2 Booth multiplier: one add/subtract-and-shift step per clock,
// full-width signed product registered on entry to DONE.
module booth_multiplier_module #(
   parameter int unsigned Width = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [Width-1:0]     a_i,
   input  logic [Width-1:0]     b_i,
   output logic [2*Width-1:0]   product_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;
   localparam logic [CntW-1:0] LastStep = CntW'(Width - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q, state_d;
   logic [Width:0]      m_q, m_d;
   logic [Width:0]      acc_q, acc_d;
   logic [Width-1:0]    mq_q, mq_d;
   logic                q1_q, q1_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [2*Width-1:0]  product_q, product_d;
   logic [Width:0]      acc_sum;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         m_q       <= '0;
         acc_q     <= '0;
         mq_q      <= '0;
         q1_q      <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         q1_q      <= q1_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   // Booth recoding of {Q[0], q_1}: 10 subtracts M, 01 adds M.
   always_comb begin
      acc_sum = acc_q;
      unique case ({mq_q[0], q1_q})
         2'b10:   acc_sum = acc_q - m_q;
         2'b01:   acc_sum = acc_q + m_q;
         default: acc_sum = acc_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      q1_d      = q1_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               m_d     = {a_i[Width-1], a_i};
               acc_d   = '0;
               mq_d    = b_i;
               q1_d    = 1'b0;
               cnt_d   = '0;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            // Arithmetic right shift of {A, Q, q_1}.
            acc_d = {acc_sum[Width], acc_sum[Width:1]};
            mq_d  = {acc_sum[0], mq_q[Width-1:1]};
            q1_d  = mq_q[0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastStep) begin
               product_d = {acc_d[Width-1:0], mq_d};
               state_d   = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign product_o = product_q;
   assign busy_o    = (state_q == StRun);
   assign done_o    = (state_q == StDone);

endmodule
